wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters SHALL be:
- DW, 32, datapath width
- AW, 5, register-address width
- NSRC, 5, number of result sources, 1..7
- LINK_OFS, 8, link-address offset added to PC
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset, in, 1, synchronous active-high reset
- in_valid, in, 1, M-stage instruction present
- in_stall, in, 1, hold W register contents
- in_flush, in, 1, insert bubble into W register
- in_pc, in, DW, instruction PC
- in_src, in, NSRC*DW, flattened result sources; source k at bits [k*DW+DW-1 : k*DW]
- in_sel, in, 3, result select
- in_wreg, in, AW, destination register
- in_we, in, 1, unconditional write enable
- in_cond_we, in, 1, write is conditional
- in_cond, in, 1, condition value for conditional write
- in_tnew, in, 2, cycles until result ready on W entry
- w_valid, out, 1, W register holds an instruction
- w_pc, out, DW, registered PC
- w_wd, out, DW, register-file write data
- w_wreg, out, AW, register-file write address
- w_we, out, 1, register-file write strobe
- w_tnew, out, 2, current Tnew for hazard unit
- w_retired, out, 32, committed-instruction count
REQ-003 Clock and reset SHALL be clk and reset, single clock domain, reset synchronous and active-high.

Function
REQ-004 Sampling: on each rising edge, captured fields SHALL be pc, sel, wreg, the resolved enable, and the selected source value.
REQ-005 Resolved enable SHALL be in_cond_we ? in_cond : in_we.
REQ-006 Selected value SHALL be:
- in_src slice [in_sel] when in_sel < NSRC
- in_pc + LINK_OFS (mod 2^DW) when in_sel == NSRC
- 0 otherwise
REQ-007 Load rule: with in_stall=0 and in_flush=0, the register SHALL load w_valid=in_valid and w_tnew=in_tnew.
REQ-008 Flush: in_flush=1 SHALL load a bubble: w_valid=0, w_we=0, w_wreg=0, w_wd=0, w_tnew=0. Flush SHALL override stall.
REQ-009 Stall: in_stall=1 with in_flush=0 SHALL hold all fields. w_tnew SHALL decrement by 1 per held cycle, saturating at 0.
REQ-010 Write strobe: w_we SHALL equal registered enable AND w_valid AND (w_wreg != 0).
REQ-011 Single write: w_we SHALL be asserted in exactly one cycle per instruction. During a stall after the first cycle, w_we SHALL be 0.
REQ-012 Hazard view: when w_we is forced 0 by REQ-010, w_wreg SHALL still reflect the captured value so the hazard unit sees the destination.
REQ-013 Retire counter: w_retired SHALL increment by 1 on every cycle in which w_valid=1 and the register loads new contents (not held, not flushed), counting the instruction leaving W. It SHALL wrap from 2^32-1 to 0.
REQ-014 Latency: all outputs SHALL be registered. Inputs SHALL reach the w_* outputs exactly one cycle after capture.
REQ-015 Bubbles: in_valid=0 SHALL load a bubble identical to REQ-008.

Reset
REQ-016 reset=1 at a rising edge SHALL set all outputs to 0, including w_retired. This SHALL override flush, stall and valid.
REQ-017 reset asserted mid-stall SHALL discard the held instruction, with no write strobe in the following cycle.

Verification
REQ-018 A bench SHALL cover:
- Link: in_sel=5, NSRC=5, in_pc=0x00003000, in_wreg=31, in_we=1 -> next cycle w_wd=0x00003008, w_wreg=31, w_we=1.
- Conditional: in_cond_we=1, in_cond=0, in_we=1 -> w_we=0. Same with in_cond=1 -> w_we=1.
- $0 write: in_wreg=0, in_we=1, source 0=0xDEADBEEF -> w_we=0, w_wd=0xDEADBEEF.
- Stall: load in_tnew=2, then stall 3 cycles -> w_tnew 2,1,0,0. w_we=1 in the first cycle only. w_retired unchanged until release.
- Flush + stall: asserted together -> bubble, w_valid=0, w_retired unchanged.
- Counter: preload via 2^32-1 retirements (or forced) -> next retirement gives w_retired=0. reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back pipeline register: captures the M-stage result, resolves the register-file
// write strobe, exposes Tnew to the hazard unit and counts retired instructions.
module wb_stage #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NSRC     = 5,
  parameter int LINK_OFS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic [DW-1:0]     in_pc,
  input  logic [NSRC*DW-1:0] in_src,
  input  logic [2:0]        in_sel,
  input  logic [AW-1:0]     in_wreg,
  input  logic              in_we,
  input  logic              in_cond_we,
  input  logic              in_cond,
  input  logic [1:0]        in_tnew,
  output logic              w_valid,
  output logic [DW-1:0]     w_pc,
  output logic [DW-1:0]     w_wd,
  output logic [AW-1:0]     w_wreg,
  output logic              w_we,
  output logic [1:0]        w_tnew,
  output logic [31:0]       w_retired
);

  localparam logic [2:0]    SEL_LINK = 3'(NSRC);
  localparam logic [DW-1:0] LINK_ADD = DW'(LINK_OFS);

  logic          valid_q,   valid_d;
  logic [DW-1:0] pc_q,      pc_d;
  logic [DW-1:0] wd_q,      wd_d;
  logic [AW-1:0] wreg_q,    wreg_d;
  logic          we_q,      we_d;
  logic [1:0]    tnew_q,    tnew_d;
  logic [31:0]   retired_q, retired_d;

  logic [DW-1:0] sel_val;
  logic          en_res;

  // Result mux: sources first, then the link address, anything above reads as zero.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == 3'(k)) sel_val = in_src[k*DW +: DW];
    end
    if (in_sel == SEL_LINK) sel_val = in_pc + LINK_ADD;
  end

  assign en_res = in_cond_we ? in_cond : in_we;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    we_d      = 1'b0;
    tnew_d    = tnew_q;
    retired_d = retired_q;

    // The instruction in W leaves whenever the register takes new contents without a flush.
    if (!in_stall && !in_flush && valid_q) retired_d = retired_q + 32'd1;

    if (in_flush || (!in_stall && !in_valid)) begin
      valid_d = 1'b0;
      pc_d    = '0;
      wd_d    = '0;
      wreg_d  = '0;
      tnew_d  = 2'd0;
    end else if (in_stall) begin
      // Held cycles keep the destination visible but never repeat the write.
      tnew_d = (tnew_q == 2'd0) ? 2'd0 : tnew_q - 2'd1;
    end else begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      wd_d    = sel_val;
      wreg_d  = in_wreg;
      we_d    = en_res && (in_wreg != '0);
      tnew_d  = in_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      wd_q      <= '0;
      wreg_q    <= '0;
      we_q      <= 1'b0;
      tnew_q    <= 2'd0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      we_q      <= we_d;
      tnew_q    <= tnew_d;
      retired_q <= retired_d;
    end
  end

  assign w_valid   = valid_q;
  assign w_pc      = pc_q;
  assign w_wd      = wd_q;
  assign w_wreg    = wreg_q;
  assign w_we      = we_q;
  assign w_tnew    = tnew_q;
  assign w_retired = retired_q;

endmodule
